// File: rtl/timing_sequencer.sv
// Sequence counter, run/interrupt flip-flops and fetch latch for the basic-computer control path.
// Optional build macro SC_WATCHDOG_EN: a free-running 7->0 wrap halts execution and sets sc_wrap_err.
module timing_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hlt,
  input  logic       clr_sc,
  input  logic [2:0] ir_opcode,
  input  logic       ir_i,
  input  logic       int_req,
  input  logic       ien_set,
  input  logic       ien_clr,
  output logic [7:0] T,
  output logic [7:0] D,
  output logic       I,
  output logic [2:0] sc,
  output logic       run,
  output logic       ien,
  output logic       r_cycle,
  output logic       sc_wrap_err
);

  localparam int T_COUNT  = 8;
  localparam int OPC_BITS = 3;
  localparam int SC_W     = $clog2(T_COUNT);
  localparam int D_W      = 2 ** OPC_BITS;
  localparam logic [T_COUNT-1:0] ONE_T = 1;
  localparam logic [D_W-1:0]     ONE_D = 1;
  localparam logic [SC_W-1:0]    SC_LAST = SC_W'(T_COUNT - 1);

  logic [SC_W-1:0]    sc_q, sc_d;
  logic               run_q, run_d;
  logic               ien_q, ien_d;
  logic               r_q, r_d;
  logic [D_W-1:0]     d_q, d_d;
  logic               i_q, i_d;
  logic [T_COUNT-1:0] t_vec;
  logic               int_end;

  assign t_vec   = run_q ? (ONE_T << sc_q) : '0;
  assign int_end = t_vec[2] & r_q;

  always_comb begin
    sc_d  = sc_q;
    run_d = run_q;
    ien_d = ien_q;
    r_d   = r_q;
    d_d   = d_q;
    i_d   = i_q;
    if (!run_q) begin
      sc_d = '0;
      if (start && !hlt) run_d = 1'b1;
    end else begin
      if (hlt) begin
        run_d = 1'b0;
        sc_d  = '0;
      end else if (int_end || clr_sc) begin
        sc_d = '0;
      end else begin
        sc_d = sc_q + 1'b1;
      end
      if (t_vec[2] && !r_q) begin
        d_d = ONE_D << ir_opcode;
        i_d = ir_i;
      end
      // Interrupt cycle end overrides any ION/IOF issued in the same cycle.
      if (int_end) begin
        r_d   = 1'b0;
        ien_d = 1'b0;
      end else begin
        if (ien_q && int_req && (t_vec[2:0] == 3'b000) && !r_q) r_d = 1'b1;
        if (ien_clr)      ien_d = 1'b0;
        else if (ien_set) ien_d = 1'b1;
      end
    end
`ifdef SC_WATCHDOG_EN
    if (run_q && !hlt && !int_end && !clr_sc && (sc_q == SC_LAST)) begin
      run_d = 1'b0;
      sc_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q  <= '0;
      run_q <= 1'b0;
      ien_q <= 1'b0;
      r_q   <= 1'b0;
      d_q   <= '0;
      i_q   <= 1'b0;
    end else begin
      sc_q  <= sc_d;
      run_q <= run_d;
      ien_q <= ien_d;
      r_q   <= r_d;
      d_q   <= d_d;
      i_q   <= i_d;
    end
  end

`ifdef SC_WATCHDOG_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (run_q && !hlt && !int_end && !clr_sc && (sc_q == SC_LAST)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign sc_wrap_err = err_q;
`else
  assign sc_wrap_err = 1'b0;
`endif

  assign T       = t_vec;
  assign D       = d_q;
  assign I       = i_q;
  assign sc      = sc_q;
  assign run     = run_q;
  assign ien     = ien_q;
  assign r_cycle = r_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed vector bench for timing_sequencer; expectations follow SC_WATCHDOG_EN when defined.
module tb_timing_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, hlt, clr_sc, ir_i, int_req, ien_set, ien_clr;
  logic [2:0] ir_opcode;
  logic [7:0] T, D;
  logic       I, run, ien, r_cycle, sc_wrap_err;
  logic [2:0] sc;

`ifdef SC_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  // control bit order: start, hlt, clr_sc, ir_i, int_req, ien_set, ien_clr
  localparam logic [6:0] NO = 7'b0000000, ST = 7'b1000000, HL = 7'b0100000, CL = 7'b0010000;
  localparam logic [6:0] II = 7'b0001000, IRQ = 7'b0000100, IS = 7'b0000010, IC = 7'b0000001;

  typedef struct {
    logic [2:0] opc;
    logic [6:0] ctl;
    logic [7:0] e_t;
    logic [7:0] e_d;
    logic       e_i;
    logic [2:0] e_sc;
    logic [3:0] e_st;  // run, ien, r_cycle, sc_wrap_err
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  timing_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .hlt(hlt), .clr_sc(clr_sc),
    .ir_opcode(ir_opcode), .ir_i(ir_i), .int_req(int_req),
    .ien_set(ien_set), .ien_clr(ien_clr),
    .T(T), .D(D), .I(I), .sc(sc), .run(run), .ien(ien),
    .r_cycle(r_cycle), .sc_wrap_err(sc_wrap_err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [2:0] opc, input logic [6:0] ctl, input logic [7:0] e_t,
                     input logic [7:0] e_d, input logic e_i, input logic [2:0] e_sc,
                     input logic [3:0] e_st);
    vec_t v;
    v.opc = opc; v.ctl = ctl; v.e_t = e_t; v.e_d = e_d;
    v.e_i = e_i; v.e_sc = e_sc; v.e_st = e_st;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [2:0] opc, input logic [6:0] ctl);
    ir_opcode = opc;
    {start, hlt, clr_sc, ir_i, int_req, ien_set, ien_clr} = ctl;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [23:0] exp);
    logic [23:0] act;
    act = {T, D, I, sc, run, ien, r_cycle, sc_wrap_err};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got T=%h D=%h I=%b sc=%0d run/ien/r/err=%b, expected T=%h D=%h I=%b sc=%0d run/ien/r/err=%b",
               name, act[23:16], act[15:8], act[7], act[6:4], act[3:0],
               exp[23:16], exp[15:8], exp[7], exp[6:4], exp[3:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(3'd0, NO);
    step();
    step();
    check("reset", 24'h0);
    rst = 1'b0;

    add(3'd0, ST,      8'h01, 8'h00, 1'b0, 3'd0, 4'b1000);
    add(3'd0, NO,      8'h02, 8'h00, 1'b0, 3'd1, 4'b1000);
    add(3'd0, NO,      8'h04, 8'h00, 1'b0, 3'd2, 4'b1000);
    add(3'd2, II,      8'h08, 8'h04, 1'b1, 3'd3, 4'b1000);
    add(3'd5, NO,      8'h10, 8'h04, 1'b1, 3'd4, 4'b1000);
    add(3'd0, NO,      8'h20, 8'h04, 1'b1, 3'd5, 4'b1000);
    add(3'd0, CL,      8'h01, 8'h04, 1'b1, 3'd0, 4'b1000);
    add(3'd0, NO,      8'h02, 8'h04, 1'b1, 3'd1, 4'b1000);
    add(3'd7, NO,      8'h04, 8'h04, 1'b1, 3'd2, 4'b1000);
    add(3'd1, NO,      8'h08, 8'h02, 1'b0, 3'd3, 4'b1000);
    add(3'd0, IS,      8'h10, 8'h02, 1'b0, 3'd4, 4'b1100);
    add(3'd0, IRQ,     8'h20, 8'h02, 1'b0, 3'd5, 4'b1110);
    add(3'd0, CL,      8'h01, 8'h02, 1'b0, 3'd0, 4'b1110);
    add(3'd6, NO,      8'h02, 8'h02, 1'b0, 3'd1, 4'b1110);
    add(3'd6, NO,      8'h04, 8'h02, 1'b0, 3'd2, 4'b1110);
    add(3'd6, IS,      8'h01, 8'h02, 1'b0, 3'd0, 4'b1000);
    add(3'd0, NO,      8'h02, 8'h02, 1'b0, 3'd1, 4'b1000);
    add(3'd0, NO,      8'h04, 8'h02, 1'b0, 3'd2, 4'b1000);
    add(3'd0, II,      8'h08, 8'h01, 1'b1, 3'd3, 4'b1000);
    add(3'd0, HL|ST,   8'h00, 8'h01, 1'b1, 3'd0, 4'b0000);
    add(3'd0, NO,      8'h00, 8'h01, 1'b1, 3'd0, 4'b0000);
    add(3'd0, IS,      8'h00, 8'h01, 1'b1, 3'd0, 4'b0000);
    add(3'd0, ST|II,   8'h01, 8'h01, 1'b1, 3'd0, 4'b1000);
    add(3'd0, ST|II,   8'h02, 8'h01, 1'b1, 3'd1, 4'b1000);
    add(3'd0, IS|II,   8'h04, 8'h01, 1'b1, 3'd2, 4'b1100);
    add(3'd0, IS|IC|II,8'h08, 8'h01, 1'b1, 3'd3, 4'b1000);
    add(3'd0, II,      8'h10, 8'h01, 1'b1, 3'd4, 4'b1000);
    add(3'd0, II,      8'h20, 8'h01, 1'b1, 3'd5, 4'b1000);
    add(3'd0, II,      8'h40, 8'h01, 1'b1, 3'd6, 4'b1000);
    add(3'd0, II,      8'h80, 8'h01, 1'b1, 3'd7, 4'b1000);
    add(3'd0, II, WD ? 8'h00 : 8'h01, 8'h01, 1'b1, 3'd0, WD ? 4'b0001 : 4'b1000);
    add(3'd0, II, WD ? 8'h00 : 8'h02, 8'h01, 1'b1, WD ? 3'd0 : 3'd1, WD ? 4'b0001 : 4'b1000);

    foreach (tbl[i]) begin
      drive(tbl[i].opc, tbl[i].ctl);
      step();
      check($sformatf("vec%0d", i),
            {tbl[i].e_t, tbl[i].e_d, tbl[i].e_i, tbl[i].e_sc, tbl[i].e_st});
    end

    drive(3'd0, NO);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_clears_sticky", 24'h0);

    // Reset in the middle of an instruction after D has been loaded.
    drive(3'd3, ST|II);
    step();
    drive(3'd3, II);
    begin
      int n;
      n = 0;
      while (T !== 8'h08 && n < 20) begin
        step();
        n++;
      end
      n_chk++;
      if (T !== 8'h08) begin
        n_fail++;
        $display("FAIL wait_T3: got T=%h after %0d cycles, expected T=08", T, n);
      end
    end
    check("pre_rst_state", {8'h08, 8'h08, 1'b1, 3'd3, 4'b1000});
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(3'd0, NO);
    check("rst_mid_instr", 24'h0);
    step();
    check("idle_after_rst", 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
